// File: rtl/acq_pkg.sv
// Shared types and default widths for the acquisition window controller.
package acq_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_POST  = 3'd3,
        ST_FLUSH = 3'd4
    } acq_state_e;

endpackage

// File: rtl/acq_out_reg.sv
// One-entry AXI-Stream output register; incoming writes that find it full and
// stalled are dropped, and a dropped tlast is carried onto the next accepted write.
module acq_out_reg
    import acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              drop,
    output logic              pending_last
);

    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              last_r;
    logic              pend_r;
    logic              accept_s;
    logic              drop_s;

    // Accept when empty or draining this cycle; otherwise the write is lost.
    always_comb begin
        accept_s = wr_en & (~valid_r | m_tready);
        drop_s   = wr_en & valid_r & ~m_tready;
    end

    // Holding register, drain tracking and pending-tlast memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                data_r  <= wr_data;
                valid_r <= 1'b1;
                last_r  <= wr_last | pend_r;
                pend_r  <= 1'b0;
            end else if (valid_r && m_tready) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else if (drop_s && wr_last) begin
                pend_r  <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign m_tdata      = data_r;
    assign m_tvalid     = valid_r;
    assign m_tlast      = last_r;
    assign drop         = drop_s;
    assign pending_last = pend_r;

endmodule

// File: rtl/acq_window_ctrl.sv
// Pre/post-trigger acquisition window: frames ADC beats around a trigger and
// streams them to DMA through a single output register.
module acq_window_ctrl
    import acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              trig_in,
    input  logic              arm,
    input  logic              abort,
    input  logic [CNT_W-1:0]  pre_len,
    input  logic [CNT_W-1:0]  post_len,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [2:0]        state_o,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W:0]    trig_pos
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    acq_state_e        state_r, state_n;
    logic [CNT_W-1:0]  pre_len_r, pre_len_n;
    logic [CNT_W-1:0]  post_len_r, post_len_n;
    logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_n;
    logic [CNT_W-1:0]  post_cnt_r, post_cnt_n;
    logic [CNT_W:0]    trig_pos_r, trig_pos_n;
    logic              overflow_r, overflow_n;
    logic              done_r, done_n;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [CNT_W-1:0]  post_inc_s;
    logic              wr_en_s;
    logic              wr_last_s;
    logic              flush_s;
    logic              drop_s;
    logic              pending_s;

    acq_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk          (ACLK),
        .rst_n        (ARESETN),
        .flush        (flush_s),
        .wr_en        (wr_en_s),
        .wr_data      (s_tdata),
        .wr_last      (wr_last_s),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .drop         (drop_s),
        .pending_last (pending_s)
    );

    // Beat counter saturates so trig_pos reports all-ones instead of wrapping.
    always_comb begin
        if (beat_cnt_r == CNT_MAX) begin
            cnt_inc_s = beat_cnt_r;
        end else begin
            cnt_inc_s = beat_cnt_r + CNT_ONE;
        end
        post_inc_s = post_cnt_r + CNT_ONE;
    end

    // Next-state, counter updates and output-register write control.
    always_comb begin
        state_n    = state_r;
        pre_len_n  = pre_len_r;
        post_len_n = post_len_r;
        beat_cnt_n = beat_cnt_r;
        post_cnt_n = post_cnt_r;
        trig_pos_n = trig_pos_r;
        overflow_n = overflow_r | drop_s;
        done_n     = 1'b0;
        wr_en_s    = 1'b0;
        wr_last_s  = 1'b0;
        flush_s    = 1'b0;

        if (abort) begin
            state_n = ST_IDLE;
            flush_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        pre_len_n  = pre_len;
                        post_len_n = (post_len == CNT_ZERO) ? CNT_ONE : post_len;
                        beat_cnt_n = CNT_ZERO;
                        post_cnt_n = CNT_ZERO;
                        trig_pos_n = {(CNT_W+1){1'b0}};
                        overflow_n = 1'b0;
                        state_n    = ST_PRE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_PRE: begin
                    if (pre_len_r == CNT_ZERO) begin
                        state_n = ST_WAIT;
                    end else if (s_tvalid) begin
                        wr_en_s    = 1'b1;
                        beat_cnt_n = cnt_inc_s;
                        if (cnt_inc_s != pre_len_r) begin
                            state_n = ST_PRE;
                        end else if (trig_in) begin
                            // Trigger on the final pre-trigger beat still opens the window.
                            trig_pos_n = {1'b0, beat_cnt_r};
                            post_cnt_n = CNT_ONE;
                            if (post_len_r == CNT_ONE) begin
                                wr_last_s = 1'b1;
                                state_n   = ST_FLUSH;
                            end else begin
                                state_n = ST_POST;
                            end
                        end else begin
                            state_n = ST_WAIT;
                        end
                    end else begin
                        state_n = ST_PRE;
                    end
                end
                ST_WAIT: begin
                    if (s_tvalid) begin
                        wr_en_s    = 1'b1;
                        beat_cnt_n = cnt_inc_s;
                        if (trig_in) begin
                            trig_pos_n = {1'b0, beat_cnt_r};
                            post_cnt_n = CNT_ONE;
                            if (post_len_r == CNT_ONE) begin
                                wr_last_s = 1'b1;
                                state_n   = ST_FLUSH;
                            end else begin
                                state_n = ST_POST;
                            end
                        end else begin
                            state_n = ST_WAIT;
                        end
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
                ST_POST: begin
                    if (s_tvalid) begin
                        wr_en_s    = 1'b1;
                        beat_cnt_n = cnt_inc_s;
                        post_cnt_n = post_inc_s;
                        if (post_inc_s == post_len_r) begin
                            wr_last_s = 1'b1;
                            state_n   = ST_FLUSH;
                        end else begin
                            state_n = ST_POST;
                        end
                    end else begin
                        state_n = ST_POST;
                    end
                end
                ST_FLUSH: begin
                    // A dropped tlast is re-issued on the next beat that gets in.
                    if (pending_s) begin
                        wr_en_s   = s_tvalid;
                        wr_last_s = 1'b1;
                    end else if (!m_tvalid || m_tready) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_FLUSH;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    flush_s = 1'b1;
                end
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            pre_len_r  <= CNT_ZERO;
            post_len_r <= CNT_ZERO;
            beat_cnt_r <= CNT_ZERO;
            post_cnt_r <= CNT_ZERO;
            trig_pos_r <= {(CNT_W+1){1'b0}};
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            pre_len_r  <= pre_len_n;
            post_len_r <= post_len_n;
            beat_cnt_r <= beat_cnt_n;
            post_cnt_r <= post_cnt_n;
            trig_pos_r <= trig_pos_n;
            overflow_r <= overflow_n;
            done_r     <= done_n;
        end
    end

    assign state_o  = state_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign trig_pos = trig_pos_r;

endmodule

// File: tb/tb_acq_window_ctrl.sv
// Directed bench for acq_window_ctrl: table of trigger-window frames plus
// hand-written stall, dropped-tlast, abort and reset sequences.
module tb_acq_window_ctrl;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam logic [63:0] BASE = 64'hA5A5_0000_0000_0000;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [DATA_W-1:0] s_tdata = 64'd0;
    logic              s_tvalid = 1'b0;
    logic              trig_in = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  pre_len = 16'd0;
    logic [CNT_W-1:0]  post_len = 16'd0;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              m_tlast;
    logic [2:0]        state_o;
    logic              done;
    logic              overflow;
    logic [CNT_W:0]    trig_pos;

    acq_window_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .trig_in(trig_in), .arm(arm), .abort(abort), .pre_len(pre_len),
        .post_len(post_len), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .state_o(state_o), .done(done),
        .overflow(overflow), .trig_pos(trig_pos)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int pre; int post; int ta; int tb;
        int chk_k; int chk_st; int exp_n; int exp_tpos;
    } vec_t;
    vec_t vecs[6];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int done_cnt;
    int c_last;
    int c_done;
    int chk_k   = -1;
    int chk_st  = 0;
    int abort_k = -1;
    logic [63:0] beat_q[$];
    logic        last_q[$];
    int          exp_idx[$];

    // Output monitor: a beat is counted when valid and ready are both high
    // in the cycle leading into the next rising edge.
    always @(negedge ACLK) begin
        cyc = cyc + 1;
        if (ARESETN && m_tvalid && m_tready) begin
            beat_q.push_back(m_tdata);
            last_q.push_back(m_tlast);
            if (m_tlast) c_last = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            c_done   = cyc;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic run_frame(input int pre, input int post, input int ta, input int tb,
                             input int nfeed, input int rlo_a, input int rlo_b);
        beat_q.delete();
        last_q.delete();
        done_cnt = 0;
        c_last   = -100;
        c_done   = -200;
        pre_len  = 16'(pre);
        post_len = 16'(post);
        arm      = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_state_pre", state_o, 1);
        chk("arm_ovf_clear", overflow, 0);
        if (pre == 0) tick();
        for (int k = 0; k < nfeed; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = BASE + 64'(k);
            trig_in  = (k == ta) || (k == tb);
            m_tready = !(k >= rlo_a && k <= rlo_b);
            abort    = (k == abort_k);
            tick();
            abort = 1'b0;
            if (k == chk_k) chk("state_mid", state_o, chk_st);
            if (k == abort_k) begin
                chk("abort_state", state_o, 0);
                chk("abort_tvalid", m_tvalid, 0);
            end
        end
        s_tvalid = 1'b0;
        trig_in  = 1'b0;
        m_tready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic check_frame(input string tag, input int tpos, input int ovf);
        int bad_data = 0;
        int bad_last = 0;
        int n = exp_idx.size();
        chk({tag, "_beats"}, beat_q.size(), n);
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            if (beat_q[i] != BASE + 64'(exp_idx[i])) bad_data++;
            if (last_q[i] != (i == n - 1)) bad_last++;
        end
        chk({tag, "_data_errs"}, bad_data, 0);
        chk({tag, "_tlast_errs"}, bad_last, 0);
        chk({tag, "_trig_pos"}, trig_pos, tpos);
        chk({tag, "_overflow"}, overflow, ovf);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_delay"}, c_done - c_last, 1);
        chk({tag, "_end_state"}, state_o, 0);
    endtask

    initial begin
        vecs[0] = '{pre: 4, post: 3, ta: 6, tb: -1, chk_k: 5, chk_st: 2, exp_n: 9, exp_tpos: 6};
        vecs[1] = '{pre: 4, post: 3, ta: 2, tb: 5,  chk_k: 4, chk_st: 2, exp_n: 8, exp_tpos: 5};
        vecs[2] = '{pre: 0, post: 0, ta: 0, tb: -1, chk_k: 0, chk_st: 4, exp_n: 1, exp_tpos: 0};
        vecs[3] = '{pre: 2, post: 1, ta: 3, tb: -1, chk_k: 1, chk_st: 2, exp_n: 4, exp_tpos: 3};
        vecs[4] = '{pre: 3, post: 2, ta: 2, tb: -1, chk_k: 2, chk_st: 3, exp_n: 4, exp_tpos: 2};
        vecs[5] = '{pre: 1, post: 5, ta: 1, tb: -1, chk_k: 0, chk_st: 2, exp_n: 6, exp_tpos: 1};

        repeat (3) tick();
        chk("rst_state", state_o, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_trig_pos", trig_pos, 0);
        ARESETN = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 6; v++) begin
            chk_k  = vecs[v].chk_k;
            chk_st = vecs[v].chk_st;
            run_frame(vecs[v].pre, vecs[v].post, vecs[v].ta, vecs[v].tb,
                      vecs[v].exp_n + 3, -1, -1);
            exp_idx.delete();
            for (int i = 0; i < vecs[v].exp_n; i++) exp_idx.push_back(i);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_tpos, 0);
        end
        chk_k = -1;

        // Stall for the first three beats: first fills the register, next two drop.
        run_frame(4, 3, 4, -1, 10, 0, 2);
        exp_idx = '{0, 3, 4, 5, 6};
        check_frame("stall", 4, 1);

        // The tlast beat itself is dropped and must reappear on a later write.
        run_frame(1, 1, 1, -1, 6, 0, 2);
        exp_idx = '{0, 3};
        check_frame("drop_last", 1, 1);

        // Abort in POST.
        abort_k = 4;
        run_frame(2, 5, 2, -1, 8, -1, -1);
        abort_k = -1;
        chk("abort_done", done_cnt, 0);
        chk("abort_idle", state_o, 0);

        // Arm and abort together leave the block idle.
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_idle", state_o, 0);
        tick();

        // Reset asserted while waiting for a trigger.
        run_frame(2, 2, -1, -1, 3, -1, -1);
        chk("pre_rst_wait", state_o, 2);
        ARESETN = 1'b0;
        #2;
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_tvalid", m_tvalid, 0);
        chk("mid_rst_tdata", m_tdata, 0);
        chk("mid_rst_trig_pos", trig_pos, 0);
        tick();
        ARESETN = 1'b1;
        done_cnt = 0;
        repeat (4) tick();
        chk("post_rst_no_done", done_cnt, 0);
        run_frame(2, 2, 3, -1, 8, -1, -1);
        exp_idx = '{0, 1, 2, 3, 4};
        check_frame("after_rst", 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
